trace_exec_packer: RTL and testbench

TRACE_EXEC_PACKER -- requirements
Module: trace_exec_packer

---
 rtl/trace_exec_packer.sv | 135 +++++++++++++
 tb/tb_trace_exec_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_exec_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trace_exec_packer                                             |
// | Brief    : Buffers retired-instruction events in a small FIFO and packs  |
// |            the head entry into the debug execution-trace word. Events    |
// |            arriving while full are dropped and flagged via overflow.     |
// |            Define OPTIMSOC_TRACE_DROP_COUNT_EN to build the saturating    |
// |            drop counter; otherwise drop_count is tied to zero.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

// Trace word field layout (debug configuration defaults)
`ifndef DEBUG_TRACE_EXEC_WIDTH
`define DEBUG_TRACE_EXEC_WIDTH       103
`define DEBUG_TRACE_EXEC_ENABLE_MSB  0
`define DEBUG_TRACE_EXEC_ENABLE_LSB  0
`define DEBUG_TRACE_EXEC_PC_MSB      32
`define DEBUG_TRACE_EXEC_PC_LSB      1
`define DEBUG_TRACE_EXEC_INSN_MSB    64
`define DEBUG_TRACE_EXEC_INSN_LSB    33
`define DEBUG_TRACE_EXEC_WBEN_MSB    65
`define DEBUG_TRACE_EXEC_WBEN_LSB    65
`define DEBUG_TRACE_EXEC_WBREG_MSB   70
`define DEBUG_TRACE_EXEC_WBREG_LSB   66
`define DEBUG_TRACE_EXEC_WBDATA_MSB  102
`define DEBUG_TRACE_EXEC_WBDATA_LSB  71
`endif

module trace_exec_packer #(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_sys,
  input  logic                               cpu_valid,
  input  logic [31:0]                        cpu_pc,
  input  logic [31:0]                        cpu_insn,
  input  logic [31:0]                        cpu_wbdata,
  input  logic                               cpu_wben,
  input  logic [4:0]                         cpu_wbreg,
  output logic [`DEBUG_TRACE_EXEC_WIDTH-1:0] trace,
  input  logic                               trace_ready,
  output logic                               overflow,
  input  logic                               overflow_clr,
  output logic [15:0]                        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];

  // Entry layout: {pc, insn, wben, wbreg, wbdata}
  logic [101:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          pop;
  logic          push;
  logic          drop;
  logic          not_empty;
  logic [101:0]  new_entry;
  logic [101:0]  head;

  assign not_empty = (count != '0);
  assign pop       = not_empty && trace_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle
  assign push      = cpu_valid && ((count < C_FULL) || pop);
  assign drop      = cpu_valid && !push;
  // Writes to r0 are architecturally void, so they are traced without wben
  assign new_entry = {cpu_pc, cpu_insn, cpu_wben && (cpu_wbreg != 5'd0),
                      cpu_wbreg, cpu_wbdata};
  assign head      = mem[rd_ptr];

  // Storage write; contents need no reset since count qualifies validity
  always_ff @(posedge clk) begin
    if (push && !rst_sys) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sticky overflow flag; a drop coinciding with a clear takes priority
  always_ff @(posedge clk) begin
    if (rst_sys)           overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef OPTIMSOC_TRACE_DROP_COUNT_EN
  logic [15:0] drop_cnt;

  // Saturating drop counter; a drop in the clear cycle restarts it at one
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      drop_cnt <= 16'h0000;
    end else if (drop) begin
      if (overflow_clr)              drop_cnt <= 16'h0001;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h0001;
    end else if (overflow_clr) begin
      drop_cnt <= 16'h0000;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = 16'h0000;
`endif

  // Trace word is derived from registered state only; zero when empty
  always_comb begin
    trace = '0;
    if (not_empty) begin
      trace[`DEBUG_TRACE_EXEC_ENABLE_MSB:`DEBUG_TRACE_EXEC_ENABLE_LSB] = 1'b1;
      trace[`DEBUG_TRACE_EXEC_PC_MSB:`DEBUG_TRACE_EXEC_PC_LSB]         = head[101:70];
      trace[`DEBUG_TRACE_EXEC_INSN_MSB:`DEBUG_TRACE_EXEC_INSN_LSB]     = head[69:38];
      trace[`DEBUG_TRACE_EXEC_WBEN_MSB:`DEBUG_TRACE_EXEC_WBEN_LSB]     = head[37];
      trace[`DEBUG_TRACE_EXEC_WBREG_MSB:`DEBUG_TRACE_EXEC_WBREG_LSB]   = head[36:32];
      trace[`DEBUG_TRACE_EXEC_WBDATA_MSB:`DEBUG_TRACE_EXEC_WBDATA_LSB] = head[31:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_exec_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trace_exec_packer                                          |
// | Brief    : Self-checking bench for trace_exec_packer: directed scenarios |
// |            followed by random traffic against a queue-based model.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

`ifndef DEBUG_TRACE_EXEC_WIDTH
`define DEBUG_TRACE_EXEC_WIDTH       103
`define DEBUG_TRACE_EXEC_ENABLE_MSB  0
`define DEBUG_TRACE_EXEC_ENABLE_LSB  0
`define DEBUG_TRACE_EXEC_PC_MSB      32
`define DEBUG_TRACE_EXEC_PC_LSB      1
`define DEBUG_TRACE_EXEC_INSN_MSB    64
`define DEBUG_TRACE_EXEC_INSN_LSB    33
`define DEBUG_TRACE_EXEC_WBEN_MSB    65
`define DEBUG_TRACE_EXEC_WBEN_LSB    65
`define DEBUG_TRACE_EXEC_WBREG_MSB   70
`define DEBUG_TRACE_EXEC_WBREG_LSB   66
`define DEBUG_TRACE_EXEC_WBDATA_MSB  102
`define DEBUG_TRACE_EXEC_WBDATA_LSB  71
`endif

module tb_trace_exec_packer;

  localparam int DEPTH = 4;
  localparam int TW    = `DEBUG_TRACE_EXEC_WIDTH;

  logic          clk = 1'b0;
  logic          rst_sys;
  logic          cpu_valid;
  logic [31:0]   cpu_pc, cpu_insn, cpu_wbdata;
  logic          cpu_wben;
  logic [4:0]    cpu_wbreg;
  logic [TW-1:0] trace;
  logic          trace_ready;
  logic          overflow;
  logic          overflow_clr;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference model state: events still to be emitted, in order
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } ev_t;

  ev_t         q[$];
  logic        m_ovf;
  logic [15:0] m_dc;

  always #5 clk = ~clk;

  trace_exec_packer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_sys      (rst_sys),
    .cpu_valid    (cpu_valid),
    .cpu_pc       (cpu_pc),
    .cpu_insn     (cpu_insn),
    .cpu_wbdata   (cpu_wbdata),
    .cpu_wben     (cpu_wben),
    .cpu_wbreg    (cpu_wbreg),
    .trace        (trace),
    .trace_ready  (trace_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] expected_trace();
    logic [TW-1:0] t;
    t = '0;
    if (q.size() > 0) begin
      t[`DEBUG_TRACE_EXEC_ENABLE_MSB:`DEBUG_TRACE_EXEC_ENABLE_LSB] = 1'b1;
      t[`DEBUG_TRACE_EXEC_PC_MSB:`DEBUG_TRACE_EXEC_PC_LSB]         = q[0].pc;
      t[`DEBUG_TRACE_EXEC_INSN_MSB:`DEBUG_TRACE_EXEC_INSN_LSB]     = q[0].insn;
      t[`DEBUG_TRACE_EXEC_WBEN_MSB:`DEBUG_TRACE_EXEC_WBEN_LSB]     = q[0].wben;
      t[`DEBUG_TRACE_EXEC_WBREG_MSB:`DEBUG_TRACE_EXEC_WBREG_LSB]   = q[0].wbreg;
      t[`DEBUG_TRACE_EXEC_WBDATA_MSB:`DEBUG_TRACE_EXEC_WBDATA_LSB] = q[0].wbdata;
    end
    return t;
  endfunction

  // One cycle: at the falling edge compare DUT against the model, then
  // apply new inputs and advance the model to its post-edge state.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic wben, input logic [4:0] wbreg, input logic [31:0] wbdata,
                      input logic rdy, input logic clr, input logic rst);
    bit   do_pop, do_push, do_drop;
    ev_t  e;
    @(negedge clk);
    if (armed) begin
      check("trace", 128'(trace), 128'(expected_trace()));
      check("overflow", 128'(overflow), 128'(m_ovf));
      check("drop_count", 128'(drop_count), 128'(m_dc));
    end
    cpu_valid = v; cpu_pc = pc; cpu_insn = insn; cpu_wben = wben;
    cpu_wbreg = wbreg; cpu_wbdata = wbdata; trace_ready = rdy;
    overflow_clr = clr; rst_sys = rst;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_dc  = 16'h0;
      armed = 1'b1;
    end else begin
      do_pop  = (q.size() > 0) && rdy;
      do_push = v && ((q.size() < DEPTH) || do_pop);
      do_drop = v && !do_push;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = pc; e.insn = insn; e.wben = wben && (wbreg != 5'd0);
        e.wbreg = wbreg; e.wbdata = wbdata;
        q.push_back(e);
      end
      if (do_drop)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`ifdef OPTIMSOC_TRACE_DROP_COUNT_EN
      if (do_drop)  m_dc = clr ? 16'h1 : ((m_dc == 16'hFFFF) ? m_dc : m_dc + 16'h1);
      else if (clr) m_dc = 16'h0;
`endif
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push_pc(input logic [31:0] pc, input logic rdy);
    step(1'b1, pc, 32'h15000000 | pc, 1'b1, 5'd7, ~pc, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst_sys = 1'b1; cpu_valid = 1'b0; cpu_pc = '0; cpu_insn = '0;
    cpu_wbdata = '0; cpu_wben = 1'b0; cpu_wbreg = '0;
    trace_ready = 1'b0; overflow_clr = 1'b0;
    m_ovf = 1'b0; m_dc = 16'h0;

    // Reset, with cpu_valid active to show it is ignored
    step(1'b1, 32'hDEAD, 32'h1, 1'b1, 5'd1, 32'h2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD, 32'h1, 1'b1, 5'd1, 32'h2, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("reset_trace_zero", 128'(trace), 128'h0);
    check("reset_overflow", 128'(overflow), 128'h0);

    // Single event appears next cycle, then trace returns to zero
    step(1'b1, 32'h100, 32'h15000000, 1'b1, 5'd3, 32'hCAFE, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("single_pc", 128'(trace[`DEBUG_TRACE_EXEC_PC_MSB:`DEBUG_TRACE_EXEC_PC_LSB]), 128'h100);
    check("single_en", 128'(trace[`DEBUG_TRACE_EXEC_ENABLE_MSB:`DEBUG_TRACE_EXEC_ENABLE_LSB]), 128'h1);
    idle(1'b1);
    check("single_after", 128'(trace), 128'h0);

    // r0 write traced with wben cleared
    step(1'b1, 32'h200, 32'h1, 1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("r0_wben", 128'(trace[`DEBUG_TRACE_EXEC_WBEN_MSB:`DEBUG_TRACE_EXEC_WBEN_LSB]), 128'h0);
    idle(1'b1);

    // Backpressure and ordering, head held stable while stalled
    for (int i = 0; i < 4; i++) push_pc(32'(4 * i), 1'b0);
    idle(1'b0);
    check("stall_head_pc", 128'(trace[`DEBUG_TRACE_EXEC_PC_MSB:`DEBUG_TRACE_EXEC_PC_LSB]), 128'h0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("order_no_ovf", 128'(overflow), 128'h0);

    // Overflow: six pushes into a four-entry FIFO with no consumer
    for (int i = 0; i < 6; i++) push_pc(32'h1000 + 32'(4 * i), 1'b0);
    idle(1'b0);
    check("ovf_set", 128'(overflow), 128'h1);
`ifdef OPTIMSOC_TRACE_DROP_COUNT_EN
    check("ovf_drops", 128'(drop_count), 128'h2);
`else
    check("ovf_drops", 128'(drop_count), 128'h0);
`endif
    // Full with simultaneous push and pop: new event goes to the tail
    push_pc(32'h2000, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("full_pushpop_ovf", 128'(overflow), 128'h1);
    // Clear, then a drop in the same cycle as a clear
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("ovf_cleared", 128'(overflow), 128'h0);
    for (int i = 0; i < 4; i++) push_pc(32'h3000 + 32'(4 * i), 1'b0);
    step(1'b1, 32'h3100, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("drop_beats_clr", 128'(overflow), 128'h1);

    // Reset mid-stream with three entries buffered
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) push_pc(32'h4000 + 32'(4 * i), 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("midrst_trace", 128'(trace), 128'h0);
    push_pc(32'h5000, 1'b0);
    idle(1'b1);
    check("midrst_next", 128'(trace[`DEBUG_TRACE_EXEC_PC_MSB:`DEBUG_TRACE_EXEC_PC_LSB]), 128'h5000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 299) == 0));
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
